lc3_operate_ctrl: RTL and testbench
===================================

Name: lc3_operate_ctrl

Overview:
Multicycle control and datapath front-end that drives the team's combinational ALU (op/A/B in, result out). Accepts one LC-3 operate instruction (ADD, AND, NOT) per handshake from the fetch side and decodes it. Reads operands from an internal 8x16 register file, drives the ALU, then writes the result back and updates NZP condition codes. Sits between the instruction fetch unit and the ALU in the LC-3 core.

Parameters:
NREGS, 8, number of general registers (fixed by the ISA; width of register fields is clog2(NREGS)=3)
XLEN, 16, data and instruction width

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
instr_valid  in  1  instruction word offered
instr  in  16  LC-3 instruction word
instr_ready  out  1  block can accept an instruction (high only in IDLE)
alu_op  out  2  ALU operation: 00 ADD, 01 AND, 10 NOT
alu_a  out  16  ALU operand A (SR1 value)
alu_b  out  16  ALU operand B (SR2 value or sign-extended imm5)
alu_out  in  16  ALU result
wb_valid  out  1  one-cycle pulse when a result is written back
wb_data  out  16  value written back (valid with wb_valid)
cc  out  3  condition codes {N,Z,P}
illegal  out  1  one-cycle pulse: accepted opcode is not ADD/AND/NOT

Behaviour:
- Reset: state=IDLE, R0-R7=0, cc=3'b010, alu_op=00, alu_a=alu_b=0, wb_valid=0, wb_data=0, illegal=0, instr_ready=1 (combinational from state).
- FSM: IDLE -> DECODE -> EXEC -> WB -> IDLE.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to DECODE. Otherwise stay in IDLE.
- DECODE: opcode=instr[15:12]. Legal opcodes: 0001 ADD, 0101 AND, 1001 NOT.
  - Illegal: pulse illegal for this cycle and return to IDLE. No writeback, cc unchanged.
  - Legal: register alu_op, alu_a=R[instr[8:6]]. alu_b=sext(instr[4:0]) if instr[5]=1, else R[instr[2:0]].
  - NOT: alu_b=0 and alu_op=10; instr[5:0] ignored.
- EXEC: alu_op/a/b held stable; capture alu_out into a result register; go to WB.
- WB: R[instr[11:9]]<=result, wb_data<=result, wb_valid pulses for one cycle.
  - cc<=100 if result[15], 010 if result==0, else 001.
  - Return to IDLE.
- Latency: handshake at cycle 0; register and cc updated at the clock edge ending cycle 3; next accept possible at cycle 4. Throughput is one instruction per 4 cycles.
- Arithmetic: 16-bit modulo (carry discarded; wrap-around required). Immediate sign extension from bit 4.
- DR==SR is legal: operands are read in DECODE, before the WB write.
- instr_valid while not in IDLE is ignored (not accepted, not lost by this block; the producer holds it).
- Reset mid-instruction: immediate return to reset values; partially executed instruction has no effect.
- alu_op/a/b are registered outputs; they hold their last values outside DECODE/EXEC.

Optional Feature:
LC3_REG_DEBUG_EN
- Defined: adds ports dbg_addr in 3 and dbg_data out 16. dbg_data=R[dbg_addr] combinationally, with no effect on the FSM.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package LCp holds:
  - opcode constants OP_ADD=4'b0001, OP_AND=4'b0101, OP_NOT=4'b1001
  - ALU op enum (ALU_ADD=2'b00, ALU_AND=2'b01, ALU_NOT=2'b10), reused by the ALU
  - FSM state enum
  - CC encodings CC_N/CC_Z/CC_P
- One natural sub-module: lc3_regfile (8x16, async reset, two combinational read ports, one synchronous write port).

Test Plan:
- Reset then 0x1225 (ADD R1,R0,#5) -> wb_valid at cycle 3 with wb_data=0x0005, R1=0x0005, cc=001.
- Then 0x967F (NOT R3,R1) -> alu_op=10, wb_data=0xFFFA, R3=0xFFFA, cc=100.
- Then 0x1843 (ADD R4,R1,R3, register mode) -> 0xFFFF, cc=100. Then 0x1AE7 (ADD R5,R3,#7) -> wrap to 0x0001, cc=001.
- 0x5460 (AND R2,R1,#0) -> alu_op=01, R2=0x0000, cc=010. Then 0x1261 (ADD R1,R1,#1) -> R1=0x0006 (DR==SR).
- 0x0000 (BR) accepted -> illegal pulses in DECODE, no wb_valid, cc unchanged, instr_ready high again next cycle.
- instr_valid held high continuously: instr_ready low in DECODE/EXEC/WB, accepts exactly every 4th cycle. Assert rst during EXEC: all registers 0, cc=010, no wb_valid.

Source files
------------

// File: rtl/lc3_operate_ctrl_pkg.sv
// Shared LC-3 operate-path definitions: opcodes, ALU ops, FSM states, CCs.
// Imported by the control block, its register file and the ALU.
package LCp;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_AND = 2'b01,
        ALU_NOT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_DECODE = 2'b01,
        S_EXEC   = 2'b10,
        S_WB     = 2'b11
    } state_e;

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    function automatic logic op_legal(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    function automatic logic [15:0] sext5(input logic [4:0] imm);
        return {{11{imm[4]}}, imm};
    endfunction

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v[15])
            return CC_N;
        else if (v == 16'h0000)
            return CC_Z;
        else
            return CC_P;
    endfunction

endpackage

// File: rtl/lc3_operate_ctrl_regfile.sv
// 8x16 general register file: async reset, two read ports, one write port.
// LC3_REG_DEBUG_EN adds a third combinational read port for inspection.
module lc3_regfile
    import LCp::*;
#(
    parameter int NREGS = 8,
    parameter int XLEN  = 16,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    output logic [XLEN-1:0] rd1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
`ifdef LC3_REG_DEBUG_EN
    ,
    input  logic [AW-1:0]   ra3,
    output logic [XLEN-1:0] rd3
`endif
);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                mem[i] <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];

`ifdef LC3_REG_DEBUG_EN
    assign rd3 = mem[ra3];
`endif

endmodule

// File: rtl/lc3_operate_ctrl.sv
// Multicycle LC-3 operate-instruction controller (ADD/AND/NOT) driving an external ALU.
// LC3_REG_DEBUG_EN adds dbg_addr/dbg_data register inspection ports.
module lc3_operate_ctrl
    import LCp::*;
#(
    parameter int NREGS = 8,
    parameter int XLEN  = 16,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] instr,
    output logic            instr_ready,
    output logic [1:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_out,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic [2:0]      cc,
    output logic            illegal
`ifdef LC3_REG_DEBUG_EN
    ,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
`endif
);

    state_e          state;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [1:0]      dec_op;
    logic [XLEN-1:0] dec_b;
    logic            rf_we;

    assign instr_ready = (state == S_IDLE);
    assign rf_we       = (state == S_WB);

    lc3_regfile #(
        .NREGS (NREGS),
        .XLEN  (XLEN)
    ) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (ir[8:6]),
        .rd1 (rd1),
        .ra2 (ir[2:0]),
        .rd2 (rd2),
        .we  (rf_we),
        .wa  (ir[11:9]),
        .wd  (result)
`ifdef LC3_REG_DEBUG_EN
        ,
        .ra3 (dbg_addr),
        .rd3 (dbg_data)
`endif
    );

    // NOT ignores the operand-B field entirely, so B is forced to zero.
    always_comb begin
        dec_op = ALU_ADD;
        dec_b  = ir[5] ? sext5(ir[4:0]) : rd2;
        case (ir[15:12])
            OP_AND: dec_op = ALU_AND;
            OP_NOT: begin
                dec_op = ALU_NOT;
                dec_b  = '0;
            end
            default: dec_op = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ir       <= '0;
            result   <= '0;
            alu_op   <= ALU_ADD;
            alu_a    <= '0;
            alu_b    <= '0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            cc       <= CC_Z;
            illegal  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        ir      <= instr;
                        // Registered here so the pulse lands in the DECODE cycle.
                        illegal <= !op_legal(instr[15:12]);
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!op_legal(ir[15:12])) begin
                        state <= S_IDLE;
                    end else begin
                        alu_op <= dec_op;
                        alu_a  <= rd1;
                        alu_b  <= dec_b;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result   <= alu_out;
                    wb_data  <= alu_out;
                    wb_valid <= 1'b1;
                    state    <= S_WB;
                end
                S_WB: begin
                    cc    <= cc_of(result);
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_operate_ctrl.sv
// Self-checking bench for lc3_operate_ctrl with a behavioural ALU and ISA-level model.
// Directed plan, continuous-valid throughput, reset mid-EXEC and random instructions.
module tb_lc3_operate_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        instr_ready;
    logic [1:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_out;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [2:0]  cc;
    logic        illegal;
`ifdef LC3_REG_DEBUG_EN
    logic [2:0]  dbg_addr = 3'd0;
    logic [15:0] dbg_data;
`endif

    int tests = 0;
    int fails = 0;

    logic [15:0] rf [8];
    logic [2:0]  ccm;

    lc3_operate_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .cc          (cc),
        .illegal     (illegal)
`ifdef LC3_REG_DEBUG_EN
        ,
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for the team's combinational ALU.
    assign alu_out = (alu_op == 2'b00) ? alu_a + alu_b :
                     (alu_op == 2'b01) ? (alu_a & alu_b) : ~alu_a;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] cc_ref(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'd0)     return 3'b010;
        return 3'b001;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        ccm = 3'b010;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [15:0] w);
        logic [15:0] a, b, r;
        logic [1:0]  eop;
        bit          legal;
        int          n;
        a     = rf[w[8:6]];
        b     = w[5] ? {{11{w[4]}}, w[4:0]} : rf[w[2:0]];
        legal = 1'b1;
        eop   = 2'b00;
        r     = 16'h0000;
        case (w[15:12])
            4'b0001: begin eop = 2'b00; r = a + b; end
            4'b0101: begin eop = 2'b01; r = a & b; end
            4'b1001: begin eop = 2'b10; b = 16'h0000; r = ~a; end
            default: legal = 1'b0;
        endcase
        n = 0;
        while (!instr_ready && n < 10) begin
            step();
            n++;
        end
        chk("ready_wait", {15'd0, instr_ready}, 16'd1);
        instr       = w;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        chk("dec_ready", {15'd0, instr_ready}, 16'd0);
        chk("dec_illegal", {15'd0, illegal}, {15'd0, !legal});
        chk("dec_wbv", {15'd0, wb_valid}, 16'd0);
        if (!legal) begin
            step();
            chk("ill_ready", {15'd0, instr_ready}, 16'd1);
            chk("ill_clear", {15'd0, illegal}, 16'd0);
            chk("ill_wbv", {15'd0, wb_valid}, 16'd0);
            chk("ill_cc", {13'd0, cc}, {13'd0, ccm});
            return;
        end
        step();
        chk("ex_op", {14'd0, alu_op}, {14'd0, eop});
        chk("ex_a", alu_a, a);
        chk("ex_b", alu_b, b);
        chk("ex_wbv", {15'd0, wb_valid}, 16'd0);
        step();
        chk("wb_valid", {15'd0, wb_valid}, 16'd1);
        chk("wb_data", wb_data, r);
        chk("wb_ready", {15'd0, instr_ready}, 16'd0);
        step();
        rf[w[11:9]] = r;
        ccm = cc_ref(r);
        chk("cc", {13'd0, cc}, {13'd0, ccm});
        chk("post_wbv", {15'd0, wb_valid}, 16'd0);
        chk("post_ready", {15'd0, instr_ready}, 16'd1);
    endtask

    task automatic readback_all();
        for (int k = 0; k < 8; k++)
            run(16'h1020 | (16'(k) << 9) | (16'(k) << 6));
    endtask

    initial begin
        logic [15:0] w;
        model_reset();
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_ready", {15'd0, instr_ready}, 16'd1);
        chk("rst_op", {14'd0, alu_op}, 16'd0);
        chk("rst_a", alu_a, 16'd0);
        chk("rst_b", alu_b, 16'd0);
        chk("rst_wbv", {15'd0, wb_valid}, 16'd0);
        chk("rst_wbd", wb_data, 16'd0);
        chk("rst_cc", {13'd0, cc}, 16'd2);
        chk("rst_ill", {15'd0, illegal}, 16'd0);

        run(16'h1225);
        chk("plan_r1", rf[1], 16'h0005);
        run(16'h967F);
        chk("plan_r3", rf[3], 16'hFFFA);
        run(16'h1843);
        run(16'h1AE7);
        chk("plan_wrap", rf[5], 16'h0001);
        run(16'h5460);
        run(16'h1261);
        chk("plan_dreqsr", rf[1], 16'h0006);
        run(16'h0000);
        readback_all();

        // Continuous valid: only every 4th cycle may accept.
        instr       = 16'h1DA1;
        instr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("cont_ready", {15'd0, instr_ready}, {15'd0, (i % 4) == 0});
            step();
        end
        instr_valid = 1'b0;
        for (int i = 0; i < 4; i++) rf[6] = rf[6] + 16'd1;
        ccm = cc_ref(rf[6]);
        chk("cont_cc", {13'd0, cc}, {13'd0, ccm});
        run(16'h1DA0);

        // Reset during EXEC discards the in-flight instruction.
        instr       = 16'h1E3F;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_wbv", {15'd0, wb_valid}, 16'd0);
        chk("mid_rst_cc", {13'd0, cc}, 16'd2);
        chk("mid_rst_ready", {15'd0, instr_ready}, 16'd1);
        step();
        rst = 1'b0;
        step();
        chk("mid_rst_wbv2", {15'd0, wb_valid}, 16'd0);
        readback_all();

        for (int i = 0; i < 60; i++) begin
            w = 16'($urandom);
            case ($urandom_range(0, 3))
                0: w[15:12] = 4'b0001;
                1: w[15:12] = 4'b0101;
                2: w[15:12] = 4'b1001;
                default: ;
            endcase
            run(w);
        end
        readback_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
